// File: rtl/vga_pkg.sv
// Shared VGA mode timing sets, 1-bit-per-channel colour encodings and the
// per-pixel flag bundle that rides the display latency pipeline.
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        int unsigned sync_pos;
    } vga_mode_t;

    localparam vga_mode_t MODE_800X600_56 = '{800, 24, 72, 128, 600, 1, 2, 22, 1};
    localparam vga_mode_t MODE_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33, 0};

    // {r,g,b}
    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_WHITE = 3'b111;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_RED   = 3'b100;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
        logic in_grid;
        logic grid_line;
    } pix_flags_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Bus width for a count of n items; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (clog2(n) > 0) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel/line counters and the raw (stage-0) sync, active and start flags
// decoded directly from the counter values.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 72,
    parameter int H_BP     = 128,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 22,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = addr_w(H_TOTAL),
    localparam int VW      = addr_w(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_frame_start,
    output logic          o_line_start
);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;
    int            w_h;
    int            w_v;

    assign w_h      = int'(r_h_cnt);
    assign w_v      = int'(r_v_cnt);
    assign w_h_last = (w_h == H_TOTAL - 1);
    assign w_v_last = (w_v == V_TOTAL - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_active      = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign o_hsync       = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
    assign o_vsync       = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
    assign o_frame_start = (w_h == 0) && (w_v == 0);
    assign o_line_start  = (w_h == 0) && (w_v < V_ACTIVE);

endmodule

// File: rtl/life_display_engine.sv
// VGA display path for the Game-of-Life board: timing, cell addressing,
// memory-latency matching pipeline and colour mux in front of the pins.
module life_display_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = int'(MODE_800X600_56.h_active),
    parameter int H_FP         = int'(MODE_800X600_56.h_fp),
    parameter int H_SYNC       = int'(MODE_800X600_56.h_sync),
    parameter int H_BP         = int'(MODE_800X600_56.h_bp),
    parameter int V_ACTIVE     = int'(MODE_800X600_56.v_active),
    parameter int V_FP         = int'(MODE_800X600_56.v_fp),
    parameter int V_SYNC       = int'(MODE_800X600_56.v_sync),
    parameter int V_BP         = int'(MODE_800X600_56.v_bp),
    parameter int SYNC_POS     = int'(MODE_800X600_56.sync_pos),
    parameter int CELL_SHIFT   = 4,
    parameter int GRID_W       = 50,
    parameter int GRID_H       = 37,
    parameter int READ_LATENCY = 1,
    parameter int RGB_W        = 1,
    parameter logic [3*RGB_W-1:0] ALIVE_COLOR  =
        {{RGB_W{COLOR_WHITE[2]}}, {RGB_W{COLOR_WHITE[1]}}, {RGB_W{COLOR_WHITE[0]}}},
    parameter logic [3*RGB_W-1:0] DEAD_COLOR   =
        {{RGB_W{COLOR_BLUE[2]}}, {RGB_W{COLOR_BLUE[1]}}, {RGB_W{COLOR_BLUE[0]}}},
    parameter logic [3*RGB_W-1:0] GRID_COLOR   =
        {{RGB_W{COLOR_GREEN[2]}}, {RGB_W{COLOR_GREEN[1]}}, {RGB_W{COLOR_GREEN[0]}}},
    parameter logic [3*RGB_W-1:0] BORDER_COLOR =
        {{RGB_W{COLOR_RED[2]}}, {RGB_W{COLOR_RED[1]}}, {RGB_W{COLOR_RED[0]}}},
    localparam int CXW = addr_w(GRID_W),
    localparam int CYW = addr_w(GRID_H)
) (
    input  logic             i_clk_36MHz,
    input  logic             i_rst_n,
    input  logic             i_show_grid,
    output logic             o_cell_req,
    output logic [CXW-1:0]   o_cell_x,
    output logic [CYW-1:0]   o_cell_y,
    input  logic             i_cell_alive,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic [RGB_W-1:0] o_red,
    output logic [RGB_W-1:0] o_green,
    output logic [RGB_W-1:0] o_blue,
    output logic             o_de,
    output logic             o_frame_start,
    output logic             o_line_start
);

    localparam int   H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   HW        = addr_w(H_TOTAL);
    localparam int   VW        = addr_w(V_TOTAL);
    localparam int   CELL_MASK = (1 << CELL_SHIFT) - 1;
    localparam logic SYNC_IDLE = (SYNC_POS == 0);

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_active, w_hsync, w_vsync, w_frame_start, w_line_start;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (i_clk_36MHz),
        .i_rst_n       (i_rst_n),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_active      (w_active),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync),
        .o_frame_start (w_frame_start),
        .o_line_start  (w_line_start)
    );

    logic       w_in_grid, w_on_boundary, w_grid_en_next;
    logic       r_grid_en;
    pix_flags_t w_flags;

    assign w_in_grid = w_active
                    && ((int'(w_h_cnt) >> CELL_SHIFT) < GRID_W)
                    && ((int'(w_v_cnt) >> CELL_SHIFT) < GRID_H);
    assign w_on_boundary = ((int'(w_h_cnt) & CELL_MASK) == 0)
                        || ((int'(w_v_cnt) & CELL_MASK) == 0);
    // Grid enable is sampled only at pixel (0,0) so a frame is drawn one way throughout.
    assign w_grid_en_next = w_frame_start ? i_show_grid : r_grid_en;

    always_comb begin
        w_flags           = '0;
        w_flags.de        = w_active;
        w_flags.hs        = w_hsync;
        w_flags.vs        = w_vsync;
        w_flags.fs        = w_frame_start;
        w_flags.ls        = w_line_start;
        w_flags.in_grid   = w_in_grid;
        w_flags.grid_line = w_in_grid && w_grid_en_next && w_on_boundary;
    end

    pix_flags_t     r_pipe [0:READ_LATENCY];
    logic [CXW-1:0] r_cell_x;
    logic [CYW-1:0] r_cell_y;

    // r_pipe[0] is the addressing stage; r_pipe[READ_LATENCY] lines up with cell_alive.
    always_ff @(posedge i_clk_36MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grid_en <= 1'b0;
            r_cell_x  <= '0;
            r_cell_y  <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_grid_en <= w_grid_en_next;
            if (w_in_grid) begin
                r_cell_x <= CXW'(w_h_cnt >> CELL_SHIFT);
                r_cell_y <= CYW'(w_v_cnt >> CELL_SHIFT);
            end
            r_pipe[0] <= w_flags;
            for (int i = 1; i <= READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_cell_req = r_pipe[0].in_grid;
    assign o_cell_x   = r_cell_x;
    assign o_cell_y   = r_cell_y;

    pix_flags_t         w_last;
    logic [3*RGB_W-1:0] w_rgb;

    assign w_last = r_pipe[READ_LATENCY];

    always_comb begin
        w_rgb = '0;
        if (w_last.de) begin
            if (!w_last.in_grid)     w_rgb = BORDER_COLOR;
            else if (w_last.grid_line) w_rgb = GRID_COLOR;
            else                     w_rgb = i_cell_alive ? ALIVE_COLOR : DEAD_COLOR;
        end
    end

    logic               r_hsync, r_vsync, r_de, r_frame_start, r_line_start;
    logic [3*RGB_W-1:0] r_rgb;

    always_ff @(posedge i_clk_36MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hsync       <= SYNC_IDLE;
            r_vsync       <= SYNC_IDLE;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_rgb         <= '0;
        end else begin
            r_hsync       <= w_last.hs ^ SYNC_IDLE;
            r_vsync       <= w_last.vs ^ SYNC_IDLE;
            r_de          <= w_last.de;
            r_frame_start <= w_last.fs;
            r_line_start  <= w_last.ls;
            r_rgb         <= w_rgb;
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_frame_start = r_frame_start;
    assign o_line_start  = r_line_start;
    assign o_red         = r_rgb[3*RGB_W-1 -: RGB_W];
    assign o_green       = r_rgb[2*RGB_W-1 -: RGB_W];
    assign o_blue        = r_rgb[RGB_W-1:0];

endmodule
